// File: rtl/rx_arb_pkg.sv
// -----------------------------------------------------------------------------
// rx_arb_pkg
// Shared types and helpers for the rx port arbiter family.
//   arb_state_e : two-state grant FSM (IDLE = no owner, LOCK = owner mid-packet)
//   rr_pick_t   : result of a round-robin search (found flag + winner index)
//   rr_pick()   : rotate-and-priority-encode search over up to MAX_REQ requesters
// -----------------------------------------------------------------------------
package rx_arb_pkg;

    localparam int MAX_REQ   = 16;
    localparam int MAX_IDX_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // Search valid[] starting at ptr, ascending, wrapping modulo num.
    // The first set bit wins. Bits at or above num are ignored. ptr must be
    // below num, so one conditional subtraction is enough for the wrap.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0]   valid,
        input logic [MAX_IDX_W-1:0] ptr,
        input int unsigned          num
    );
        rr_pick_t    res;
        int unsigned pos;
        res = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= num) begin
                pos = pos - num;
            end
            if ((k < num) && !res.found && valid[pos[MAX_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = pos[MAX_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// -----------------------------------------------------------------------------
// rr_pick_comb
// Combinational round-robin winner search, reusable by any arbiter.
//   valid_i : per-requester request bits
//   ptr_i   : index with highest priority this cycle
//   found_o : at least one request bit is set
//   idx_o   : winning requester (first set bit at or after ptr_i, wrapping)
// -----------------------------------------------------------------------------
module rr_pick_comb
    import rx_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    rr_pick_t pick;

    assign pick    = rr_pick(MAX_REQ'(valid_i), MAX_IDX_W'(ptr_i), N);
    assign found_o = pick.found;
    assign idx_o   = pick.idx[IDX_W-1:0];

    // The helper works at the maximum index width; the top bits are always
    // zero for smaller arbiters.
    generate
        if (IDX_W < MAX_IDX_W) begin : g_idx_hi
            logic unused_idx_hi;
            assign unused_idx_hi = ^pick.idx[MAX_IDX_W-1:IDX_W];
        end
    endgenerate

endmodule

// File: rtl/rx_port_arbiter.sv
// -----------------------------------------------------------------------------
// rx_port_arbiter
// Packet-granular round-robin arbiter sharing one registered rx datapath
// between NUM_REQ valid/ready/last requesters. A grant is held from the first
// accepted beat until that requester's last beat is accepted.
//   clk, rst_n : clock, asynchronous active-low reset
//   sched_en   : global enable; low blocks all transfers and freezes the FSM
//   req_valid  : per-requester beat valid
//   req_data   : packed beats, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last   : per-requester end-of-packet flag
//   req_ready  : per-requester accept (combinational, one-hot or zero)
//   rx_en      : registered beat strobe
//   rx_data    : registered beat data (holds when rx_en is low)
//   rx_id      : registered source index (holds when rx_en is low)
//   rx_last    : registered end-of-packet flag
//   busy       : FSM is in LOCK
// -----------------------------------------------------------------------------
module rx_port_arbiter
    import rx_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_REQ    = 4,
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sched_en,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rx_en,
    output logic [DATA_WIDTH-1:0]         rx_data,
    output logic [ID_WIDTH-1:0]           rx_id,
    output logic                          rx_last,
    output logic                          busy
);

    arb_state_e            state_q, state_d;
    logic [ID_WIDTH-1:0]   owner_q, owner_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic                  rx_en_q, rx_en_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [ID_WIDTH-1:0]   rx_id_q, rx_id_d;
    logic                  rx_last_q, rx_last_d;

    logic                  win_found;
    logic [ID_WIDTH-1:0]   win_idx;
    logic                  grant_any;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] grant_beat;
    logic                  grant_last;
    logic [ID_WIDTH-1:0]   grant_idx_inc;
    logic [DATA_WIDTH-1:0] req_beat [NUM_REQ];

    rr_pick_comb #(
        .N     (NUM_REQ),
        .IDX_W (ID_WIDTH)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .found_o (win_found),
        .idx_o   (win_idx)
    );

    // Unpack the beat bus so the grant mux is a plain array index.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_beat[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_ready[gi] = grant_any && (grant_idx == ID_WIDTH'(gi));
        end
    endgenerate

    // In LOCK the owner keeps the grant regardless of its valid, so a bubble
    // never lets another requester in.
    assign grant_idx     = (state_q == LOCK) ? owner_q : win_idx;
    assign grant_any     = sched_en && ((state_q == LOCK) || win_found);
    assign xfer          = grant_any && req_valid[grant_idx];
    assign grant_beat    = req_beat[grant_idx];
    assign grant_last    = req_last[grant_idx];
    assign grant_idx_inc = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // In LOCK grant_idx equals owner_q, so one rule set covers both states:
    // a last beat releases the grant and moves the pointer past the sender,
    // any other beat (re)asserts ownership.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        rx_en_d   = 1'b0;
        rx_last_d = 1'b0;
        rx_data_d = rx_data_q;
        rx_id_d   = rx_id_q;
        if (xfer) begin
            rx_en_d   = 1'b1;
            rx_last_d = grant_last;
            rx_data_d = grant_beat;
            rx_id_d   = grant_idx;
            if (grant_last) begin
                state_d  = IDLE;
                rr_ptr_d = grant_idx_inc;
            end else begin
                state_d  = LOCK;
                owner_d  = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            rx_en_q   <= 1'b0;
            rx_data_q <= '0;
            rx_id_q   <= '0;
            rx_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            rx_en_q   <= rx_en_d;
            rx_data_q <= rx_data_d;
            rx_id_q   <= rx_id_d;
            rx_last_q <= rx_last_d;
        end
    end

    assign rx_en   = rx_en_q;
    assign rx_data = rx_data_q;
    assign rx_id   = rx_id_q;
    assign rx_last = rx_last_q;
    assign busy    = (state_q == LOCK);

endmodule

// File: tb/tb_rx_port_arbiter.sv
module tb_rx_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        sched_en;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        rx_en;
    logic [7:0]  rx_data;
    logic [1:0]  rx_id;
    logic        rx_last;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who holds a packet (-1 = nobody), who has priority,
    // and what the registered outputs should show.
    int          m_owner;
    int          m_ptr;
    logic        m_en;
    logic [7:0]  m_data;
    logic [1:0]  m_id;
    logic        m_last;

    rx_port_arbiter #(
        .DATA_WIDTH (8),
        .NUM_REQ    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sched_en  (sched_en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .rx_en     (rx_en),
        .rx_data   (rx_data),
        .rx_id     (rx_id),
        .rx_last   (rx_last),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_en    = 1'b0;
        m_data  = 8'h00;
        m_id    = 2'd0;
        m_last  = 1'b0;
    endtask

    // Who may send this cycle: the packet holder, else the first valid
    // requester at or after the priority pointer.
    function automatic int model_grant(input logic [3:0] v, input logic s);
        if (!s) return -1;
        if (m_owner >= 0) return m_owner;
        for (int k = 0; k < 4; k++) begin
            if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        chk("rx_en", 32'(rx_en), 32'(m_en));
        chk("rx_data", 32'(rx_data), 32'(m_data));
        chk("rx_id", 32'(rx_id), 32'(m_id));
        chk("rx_last", 32'(rx_last), 32'(m_last));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
    endtask

    // One cycle: drive at negedge, check ready, clock, check outputs at negedge.
    task automatic step(input logic [3:0] v, input logic [3:0] l,
                        input logic [31:0] d, input logic s);
        int         g;
        logic [3:0] exp_ready;
        req_valid = v;
        req_last  = l;
        req_data  = d;
        sched_en  = s;
        #1;
        g = model_grant(v, s);
        exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        @(posedge clk);
        if (g >= 0 && v[g]) begin
            m_en   = 1'b1;
            m_data = d[g*8 +: 8];
            m_id   = 2'(g);
            m_last = l[g];
            if (l[g]) begin
                m_owner = -1;
                m_ptr   = (g + 1) % 4;
            end else begin
                m_owner = g;
            end
        end else begin
            m_en   = 1'b0;
            m_last = 1'b0;
        end
        @(negedge clk);
        check_outputs();
        $display("cyc v=%b l=%b s=%0d grant=%0d -> rx_en=%0d id=%0d data=%02h last=%0d busy=%0d",
                 v, l, s, g, rx_en, rx_id, rx_data, rx_last, busy);
    endtask

    initial begin
        logic [3:0]  rv;
        logic [3:0]  rl;
        logic [31:0] rd;
        logic        rs;

        // 1. Reset then idle
        rst_n     = 1'b0;
        sched_en  = 1'b1;
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        req_data  = 32'h0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check_outputs();
            chk("reset_ready", 32'(req_ready), 32'h0);
        end
        rst_n = 1'b1;
        repeat (3) step(4'b0000, 4'b0000, 32'h0, 1'b1);

        // 2. Single-beat round robin: ids 0,1,2,3,0 back to back
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 4'b1111, 32'h13121110, 1'b1);
            chk("rr_id_seq", 32'(rx_id), 32'(k % 4));
            chk("rr_en", 32'(rx_en), 32'h1);
        end

        // 5. Wrap-around: req3 alone, then req0 and req2 contend
        step(4'b1000, 4'b1000, 32'h33000000, 1'b1);
        chk("wrap_req3", 32'(rx_id), 32'd3);
        step(4'b0101, 4'b0101, 32'h00520050, 1'b1);
        chk("wrap_req0_wins", 32'(rx_id), 32'd0);
        step(4'b0101, 4'b0101, 32'h00520050, 1'b1);
        chk("wrap_then_req2", 32'(rx_id), 32'd2);

        // 3. Packet lock: req0 sends A0,A1,A2 while req1 waits
        step(4'b0011, 4'b0010, 32'h0000B1A0, 1'b1);
        step(4'b0011, 4'b0010, 32'h0000B1A1, 1'b1);
        chk("lock_ready1", 32'(req_ready[1]), 32'h0);
        step(4'b0011, 4'b0011, 32'h0000B1A2, 1'b1);
        chk("lock_last_a2", 32'({rx_last, rx_data}), 32'h1A2);
        step(4'b0010, 4'b0010, 32'h0000B100, 1'b1);
        chk("lock_then_req1", 32'(rx_id), 32'd1);

        // 4. Bubble then sched_en stall mid-packet from req2
        step(4'b0110, 4'b0010, 32'h00C0B200, 1'b1);
        repeat (2) step(4'b0010, 4'b0010, 32'h0000B200, 1'b1);
        repeat (3) step(4'b0110, 4'b0010, 32'h00C1B200, 1'b0);
        step(4'b0110, 4'b0010, 32'h00C1B200, 1'b1);
        chk("resume_owner", 32'(rx_id), 32'd2);
        step(4'b0110, 4'b0110, 32'h00C2B200, 1'b1);

        // 6. Asynchronous reset during beat 2 of a 4-beat packet from req1
        step(4'b0010, 4'b0000, 32'h0000D000, 1'b1);
        step(4'b0010, 4'b0000, 32'h0000D100, 1'b1);
        #2;
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0000, 4'b0000, 32'h0, 1'b1);
        chk("no_trunc_last", 32'(rx_last), 32'h0);
        step(4'b1111, 4'b1111, 32'hE3E2E1E0, 1'b1);
        chk("post_reset_req0", 32'(rx_id), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rv = 4'($urandom);
            rl = 4'($urandom) & 4'($urandom);
            rd = $urandom;
            rs = ($urandom_range(0, 9) != 0);
            step(rv, rl, rd, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_port_arbiter.md
Name: rx_port_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single registered rx_en/rx_data datapath between NUM_REQ requesters.
- Each requester presents a valid/ready/last stream. The arbiter grants one requester at a time and holds the grant until that requester's last beat is accepted.
- Outputs are registered, with a source id and a last flag, and drive the datapath's rx_en/rx_data inputs directly.

Parameters:
- DATA_WIDTH, 8, beat width; must match the downstream datapath.
- NUM_REQ, 4, number of requesters; legal range 2..16.
- ID_WIDTH, $clog2(NUM_REQ), localparam; width of the source id.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- sched_en  in  1  global enable; when low no beat is accepted.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed beats; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  final beat of the packet; qualified by req_valid.
- req_ready  out  NUM_REQ  per-requester accept (combinational).
- rx_en  out  1  registered beat strobe to the datapath.
- rx_data  out  DATA_WIDTH  registered beat data.
- rx_id  out  ID_WIDTH  index of the source requester.
- rx_last  out  1  registered last flag.
- busy  out  1  high while the FSM is in LOCK.

Behaviour:
- Reset (asynchronous, rst_n low):
  - rx_en, rx_data, rx_id, rx_last and busy are all 0.
  - State is IDLE, owner is 0, rr_ptr is 0, so requester 0 has first priority.
- FSM states: IDLE (no owner) and LOCK (owner holds the grant mid-packet).
- Winner selection in IDLE:
  - Search req_valid starting at rr_ptr, ascending, wrapping modulo NUM_REQ.
  - The first set bit wins. Selection is combinational.
- req_ready[i] is high only when sched_en is 1 and either:
  - state is IDLE, some req_valid is set, and i is the winner; or
  - state is LOCK and i == owner.
  - At most one req_ready bit is ever high. req_ready does not depend on req_valid[i] in LOCK.
- Transfer occurs when req_valid[i] and req_ready[i] are both high.
- Output timing:
  - On the clock edge of a transfer: rx_en<=1, rx_data<=beat, rx_id<=i, rx_last<=req_last[i].
  - On any cycle without a transfer: rx_en<=0, rx_last<=0; rx_data and rx_id hold.
  - Latency from transfer to rx_en is exactly 1 cycle. Throughput is 1 beat per cycle, including back-to-back packets from different requesters.
- State transitions:
  - IDLE, transfer with last=1: stay IDLE; rr_ptr <= (i+1) mod NUM_REQ. This covers single-beat packets.
  - IDLE, transfer with last=0: go to LOCK; owner <= i.
  - LOCK, owner transfer with last=0: stay in LOCK.
  - LOCK, owner transfer with last=1: go to IDLE; rr_ptr <= (owner+1) mod NUM_REQ.
  - LOCK, owner req_valid low: bubble cycle with rx_en=0; the grant is held and other requesters are ignored.
- sched_en low: all req_ready are 0, the FSM and rr_ptr freeze, and rx_en goes 0 on the next edge. A packet in progress resumes with the same owner when sched_en returns high.
- rr_ptr advances only on packet completion, never on a bubble or a stall.
- busy = (state == LOCK), registered with the state.
- Reset asserted mid-packet: the packet is truncated and no rx_last is emitted. Requesters must restart the packet after reset.
- The downstream datapath has no backpressure, so every rx_en beat is consumed.

Decomposition:
- Shared package rx_arb_pkg:
  - state enum {IDLE, LOCK};
  - function rr_pick(valid, ptr), returning the found flag and the index.
- One natural sub-module, rr_pick_comb: the combinational rotate-and-priority-encode winner search, reusable by other arbiters in the block.
- FSM, pointer and output registers stay in the top module.

Test Plan:
1. Reset then idle: hold rst_n=0 for 3 cycles, then all req_valid=0 -> rx_en=0, busy=0, req_ready=0 every cycle.
2. Single-beat round robin: NUM_REQ=4, all four valid with last=1 continuously, data=0x10+i -> rx_id sequence 0,1,2,3,0 on consecutive cycles, rx_data 0x10..0x13, rx_en high every cycle.
3. Packet lock: req0 sends a 3-beat packet (0xA0,0xA1,0xA2) while req1 is valid throughout -> rx_id=0 for 3 beats with rx_last only on 0xA2, then req1's beat with rx_id=1; req_ready[1]=0 during LOCK.
4. Bubble and sched_en stall:
   - Owner drops req_valid for 2 cycles mid-packet -> rx_en=0 for 2 cycles, busy=1, no other grant.
   - Then sched_en=0 for 3 cycles -> all req_ready=0 and the packet resumes with the same owner.
5. Wrap-around and pointer: last grant to req3, then only req0 and req2 valid -> req0 wins; a following single-beat from req0 -> next winner is req2.
6. Asynchronous reset mid-packet: assert rst_n low between clock edges during beat 2 of 4 -> outputs 0 immediately, state IDLE, rr_ptr=0, and no rx_last emitted.
